// File: rtl/cpuc_ram_loader.sv
// RAM front-end for the CPUC core: passes core requests through to the single-port RAM, or
// takes the RAM over to fill words [0, len) from a little-endian byte stream.
module cpuc_ram_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MEM_SIZE   = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,

    input  logic [ADDR_WIDTH-1:0] core_address,
    input  logic                  core_wren,
    input  logic [DATA_WIDTH-1:0] core_data,
    output logic [DATA_WIDTH-1:0] core_q,
    output logic                  core_stall,

    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_wren,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q,

    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int unsigned BPW       = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [ADDR_WIDTH:0]  MAX_LEN   = (ADDR_WIDTH + 1)'(MEM_SIZE);
    localparam logic [CNT_WIDTH-1:0] LAST_BYTE = CNT_WIDTH'(BPW - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   ptr_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic [DATA_WIDTH-1:0]   shreg_q;
    logic [ADDR_WIDTH:0]     ptr_inc;

    // One bit wider than the pointer so a full-size load (len == MEM_SIZE) compares cleanly.
    assign ptr_inc = {1'b0, ptr_q} + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            shreg_q    <= '0;
            byte_ready <= 1'b0;
            core_stall <= 1'b0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load_start) begin
                        if (load_len == '0) begin
                            load_done <= 1'b1;
                        end else if (load_len > MAX_LEN) begin
                            load_err <= 1'b1;
                        end else begin
                            state_q    <= COLLECT;
                            len_q      <= load_len;
                            ptr_q      <= '0;
                            cnt_q      <= '0;
                            byte_ready <= 1'b1;
                            core_stall <= 1'b1;
                            load_busy  <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (byte_valid && byte_ready) begin
                        // Shift in from the top so the first byte ends up in the low lane.
                        shreg_q <= {byte_data, shreg_q[DATA_WIDTH-1:8]};
                        if (cnt_q == LAST_BYTE) begin
                            state_q    <= WRITE;
                            byte_ready <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    ptr_q <= ptr_inc[ADDR_WIDTH-1:0];
                    cnt_q <= '0;
                    if (ptr_inc == len_q) begin
                        state_q   <= DONE;
                        load_done <= 1'b1;
                    end else begin
                        state_q    <= COLLECT;
                        byte_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    core_stall <= 1'b0;
                    load_busy  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    byte_ready <= 1'b0;
                    core_stall <= 1'b0;
                    load_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Core writes are dropped whenever the loader owns the RAM.
    always_comb begin
        ram_address = core_address;
        ram_wren    = core_wren;
        ram_data    = core_data;
        if (state_q != IDLE) begin
            ram_address = ptr_q;
            ram_wren    = (state_q == WRITE);
            ram_data    = shreg_q;
        end
    end

    assign core_q = ram_q;

endmodule
